// File: rtl/pipeline_ctrl.sv
// Central pipeline control: merges per-stage stall requests into a prefix pause
// vector and sequences exception flush/redirect, memory drain and IDLE waiting.
package pipeline_ctrl_pkg;
    localparam int unsigned CTRL_STAGES = 8;

    typedef struct packed {
        logic [CTRL_STAGES-1:0] pause;
        logic                   exception_flush;
    } ctrl_t;
endpackage

module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned NUM_STAGES = CTRL_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] pause_request,
    input  logic                  exception_valid,
    input  logic [PC_WIDTH-1:0]   exception_pc,
    input  logic                  idle_valid,
    input  logic                  interrupt_pending,
    input  logic                  mem_busy,
    output ctrl_t                 ctrl,
    output logic                  redirect_valid,
    output logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [31:0]           stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_DRAIN,
        S_IDLE
    } state_t;

    // IDLE freezes everything up to and including stage 5.
    localparam logic [NUM_STAGES-1:0] IDLE_MASK = {{(NUM_STAGES-6){1'b0}}, 6'h3F};

    state_t                r_state;
    logic                  r_flush;
    logic [PC_WIDTH-1:0]   r_redirect_pc;
    logic [31:0]           r_stall_cycles;
    logic [NUM_STAGES-1:0] w_pause;
    logic                  w_any;

    // A stalled stage must also hold every stage upstream of it.
    always_comb begin
        w_any   = 1'b0;
        w_pause = '0;
        for (int unsigned i = NUM_STAGES; i > 0; i--) begin
            w_any        = w_any | pause_request[i-1];
            w_pause[i-1] = w_any;
        end
        case (r_state)
            S_IDLE:  w_pause    = w_pause | IDLE_MASK;
            S_DRAIN: w_pause[0] = 1'b1;
            S_FLUSH: w_pause    = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_flush <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (exception_valid) begin
                        r_state       <= S_FLUSH;
                        r_flush       <= 1'b1;
                        r_redirect_pc <= exception_pc;
                    end else if (idle_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                S_FLUSH: r_state <= mem_busy ? S_DRAIN : S_RUN;
                S_DRAIN: begin
                    if (!mem_busy) r_state <= S_RUN;
                end
                S_IDLE: begin
                    if (exception_valid) begin
                        r_state       <= S_FLUSH;
                        r_flush       <= 1'b1;
                        r_redirect_pc <= exception_pc;
                    end else if (interrupt_pending) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_pause[0] && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign ctrl.pause           = w_pause;
    assign ctrl.exception_flush = r_flush;
    assign redirect_valid       = r_flush;
    assign redirect_pc          = r_redirect_pc;
    assign stall_cycles         = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int MD_RUN   = 0;
    localparam int MD_FLUSH = 1;
    localparam int MD_DRAIN = 2;
    localparam int MD_IDLE  = 3;

    logic        clk;
    logic        rst;
    logic [7:0]  pause_request;
    logic        exception_valid;
    logic [31:0] exception_pc;
    logic        idle_valid;
    logic        interrupt_pending;
    logic        mem_busy;
    ctrl_t       ctrl;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] stall_cycles;

    int          errors;
    int          checks;

    int          m_mode;
    logic [31:0] m_rpc;
    logic [31:0] m_stall;

    pipeline_ctrl #(.PC_WIDTH(32), .NUM_STAGES(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .pause_request     (pause_request),
        .exception_valid   (exception_valid),
        .exception_pc      (exception_pc),
        .idle_valid        (idle_valid),
        .interrupt_pending (interrupt_pending),
        .mem_busy          (mem_busy),
        .ctrl              (ctrl),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .stall_cycles      (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stage j pauses iff some stage at or above j requested a stall.
    function automatic logic [7:0] model_pause();
        logic [7:0] p;
        for (int j = 0; j < 8; j++) p[j] = ((pause_request >> j) != 8'd0);
        if (m_mode == MD_IDLE)  p = p | 8'h3F;
        if (m_mode == MD_DRAIN) p = p | 8'h01;
        if (m_mode == MD_FLUSH) p = 8'h00;
        return p;
    endfunction

    function automatic logic model_flush();
        return (m_mode == MD_FLUSH);
    endfunction

    task automatic model_reset();
        m_mode  = MD_RUN;
        m_rpc   = 32'h0;
        m_stall = 32'h0;
    endtask

    // Apply inputs in the low phase; outputs are settled 1 time unit later.
    task automatic drive(input logic [7:0] req, input logic ev, input logic [31:0] pc,
                         input logic idl, input logic irq, input logic busy);
        @(negedge clk);
        pause_request     = req;
        exception_valid   = ev;
        exception_pc      = pc;
        idle_valid        = idl;
        interrupt_pending = irq;
        mem_busy          = busy;
        #1;
    endtask

    // Update the model with what the upcoming rising edge will sample.
    task automatic advance();
        logic [7:0] p;
        p = model_pause();
        if (p[0] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        case (m_mode)
            MD_RUN: begin
                if (exception_valid) begin m_mode = MD_FLUSH; m_rpc = exception_pc; end
                else if (idle_valid) m_mode = MD_IDLE;
            end
            MD_FLUSH: m_mode = mem_busy ? MD_DRAIN : MD_RUN;
            MD_DRAIN: if (!mem_busy) m_mode = MD_RUN;
            default: begin
                if (exception_valid) begin m_mode = MD_FLUSH; m_rpc = exception_pc; end
                else if (interrupt_pending) m_mode = MD_RUN;
            end
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pause_request = 8'h00; exception_valid = 1'b0; exception_pc = 32'h0;
        idle_valid = 1'b0; interrupt_pending = 1'b0; mem_busy = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({ctrl.pause, ctrl.exception_flush, redirect_valid, redirect_pc, stall_cycles} !== 74'd0) begin
            errors++;
            $display("FAIL reset_outputs: got pause=%h fl=%b rv=%b rpc=%h st=%h, want all zero",
                     ctrl.pause, ctrl.exception_flush, redirect_valid, redirect_pc, stall_cycles);
        end
        pause_request = 8'h04;
        #1;
        checks++;
        if (ctrl.pause !== 8'h07) begin
            errors++;
            $display("FAIL reset_pause_follows: got %h want 07", ctrl.pause);
        end
        pause_request = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pause();
        drive(8'h10, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl.pause !== 8'h1F) begin
            errors++;
            $display("FAIL pause_prefix: got %h want 1f", ctrl.pause);
        end
        advance();
        drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl.pause !== 8'h00 || stall_cycles !== 32'd1) begin
            errors++;
            $display("FAIL pause_release: got pause=%h st=%0d want pause=00 st=1", ctrl.pause, stall_cycles);
        end
        advance();
        for (int i = 0; i < 24; i++) begin
            drive(8'($urandom), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (ctrl.pause !== model_pause() || stall_cycles !== m_stall) begin
                errors++;
                $display("FAIL pause_random[%0d]: got pause=%h st=%0d want pause=%h st=%0d",
                         i, ctrl.pause, stall_cycles, model_pause(), m_stall);
            end
            advance();
        end
    endtask

    task automatic test_flush();
        drive(8'h00, 1'b1, 32'h1C00_0000, 1'b0, 1'b0, 1'b0);
        advance();
        drive(8'($urandom), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl.exception_flush !== 1'b1 || redirect_valid !== 1'b1 ||
            redirect_pc !== 32'h1C00_0000 || ctrl.pause !== 8'h00) begin
            errors++;
            $display("FAIL flush_cycle: got fl=%b rv=%b rpc=%h pause=%h want 1 1 1c000000 00",
                     ctrl.exception_flush, redirect_valid, redirect_pc, ctrl.pause);
        end
        advance();
        drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl.exception_flush !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h1C00_0000) begin
            errors++;
            $display("FAIL flush_end: got fl=%b rv=%b rpc=%h want 0 0 1c000000",
                     ctrl.exception_flush, redirect_valid, redirect_pc);
        end
        advance();
    endtask

    task automatic test_drain();
        logic [31:0] st0;
        int          held;
        logic [0:4]  busy_seq;
        logic [0:4]  ev_seq;
        busy_seq = 5'b11100;
        ev_seq   = 5'b00100;
        held = 0;
        drive(8'h00, 1'b1, 32'h2000_0040, 1'b0, 1'b0, 1'b0);
        advance();
        st0 = m_stall;
        for (int c = 0; c < 5; c++) begin
            drive(8'h00, ev_seq[c], 32'hDEAD_BEE0, 1'b0, 1'b0, busy_seq[c]);
            if (ctrl.pause[0] === 1'b1) held++;
            checks++;
            if (ctrl.pause !== model_pause() || ctrl.exception_flush !== model_flush() ||
                redirect_valid !== model_flush() || redirect_pc !== m_rpc || stall_cycles !== m_stall) begin
                errors++;
                $display("FAIL drain_cycle[%0d]: got pause=%h fl=%b rpc=%h st=%0d want pause=%h fl=%b rpc=%h st=%0d",
                         c, ctrl.pause, ctrl.exception_flush, redirect_pc, stall_cycles,
                         model_pause(), model_flush(), m_rpc, m_stall);
            end
            advance();
        end
        checks++;
        if (held != 3 || stall_cycles !== st0 + 32'd3 || redirect_pc !== 32'h2000_0040) begin
            errors++;
            $display("FAIL drain_summary: got held=%0d dst=%0d rpc=%h want held=3 dst=3 rpc=20000040",
                     held, stall_cycles - st0, redirect_pc);
        end
    endtask

    task automatic test_idle();
        drive(8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        advance();
        for (int i = 0; i < 6; i++) begin
            drive(8'($urandom), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (ctrl.pause[5:0] !== 6'h3F || ctrl.pause !== model_pause() || stall_cycles !== m_stall) begin
                errors++;
                $display("FAIL idle_hold[%0d]: got pause=%h st=%0d want pause=%h st=%0d",
                         i, ctrl.pause, stall_cycles, model_pause(), m_stall);
            end
            advance();
        end
        drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ctrl.pause !== 8'h3F) begin
            errors++;
            $display("FAIL idle_irq_cycle: got %h want 3f", ctrl.pause);
        end
        advance();
        drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl.pause !== 8'h00) begin
            errors++;
            $display("FAIL idle_release: got %h want 00", ctrl.pause);
        end
        advance();
        drive(8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        advance();
        drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        advance();
        drive(8'h00, 1'b1, 32'h1C00_1000, 1'b0, 1'b0, 1'b0);
        advance();
        drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl.exception_flush !== 1'b1 || redirect_valid !== 1'b1 ||
            redirect_pc !== 32'h1C00_1000 || ctrl.pause !== 8'h00) begin
            errors++;
            $display("FAIL idle_exception: got fl=%b rv=%b rpc=%h pause=%h want 1 1 1c001000 00",
                     ctrl.exception_flush, redirect_valid, redirect_pc, ctrl.pause);
        end
        advance();
    endtask

    task automatic test_priority();
        drive(8'h00, 1'b1, 32'h0000_3000, 1'b1, 1'b0, 1'b0);
        advance();
        drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl.exception_flush !== 1'b1 || redirect_pc !== 32'h0000_3000) begin
            errors++;
            $display("FAIL prio_flush: got fl=%b rpc=%h want 1 00003000", ctrl.exception_flush, redirect_pc);
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (ctrl.pause !== 8'h00 || ctrl.exception_flush !== 1'b0) begin
                errors++;
                $display("FAIL prio_no_idle[%0d]: got pause=%h fl=%b want 00 0", i, ctrl.pause, ctrl.exception_flush);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                  ($urandom_range(0, 15) == 0), $urandom,
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 1) == 0));
            checks++;
            if (ctrl.pause !== model_pause() || ctrl.exception_flush !== model_flush() ||
                redirect_valid !== model_flush() || redirect_pc !== m_rpc || stall_cycles !== m_stall) begin
                errors++;
                $display("FAIL random[%0d]: got pause=%h fl=%b rv=%b rpc=%h st=%0d want pause=%h fl=%b rpc=%h st=%0d",
                         i, ctrl.pause, ctrl.exception_flush, redirect_valid, redirect_pc, stall_cycles,
                         model_pause(), model_flush(), m_rpc, m_stall);
            end
            advance();
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20 && m_mode != MD_RUN; i++) begin
            drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            advance();
        end
        drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        advance();
        force dut.r_stall_cycles = 32'hFFFF_FFFD;
        #1;
        release dut.r_stall_cycles;
        m_stall = 32'hFFFF_FFFD;
        for (int i = 0; i < 5; i++) begin
            drive(8'h01, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (stall_cycles !== m_stall) begin
                errors++;
                $display("FAIL sat_step[%0d]: got %h want %h", i, stall_cycles, m_stall);
            end
            advance();
        end
        drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_cycles !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sat_hold: got %h want ffffffff", stall_cycles);
        end
        advance();
    endtask

    task automatic test_async_reset();
        drive(8'h00, 1'b1, 32'h1C00_2000, 1'b0, 1'b0, 1'b0);
        advance();
        drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        advance();
        drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ctrl.pause !== 8'h01 || redirect_pc !== 32'h1C00_2000) begin
            errors++;
            $display("FAIL areset_in_drain: got pause=%h rpc=%h want 01 1c002000", ctrl.pause, redirect_pc);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ctrl.pause, ctrl.exception_flush, redirect_valid, redirect_pc, stall_cycles} !== 74'd0) begin
            errors++;
            $display("FAIL areset_outputs: got pause=%h fl=%b rv=%b rpc=%h st=%h, want all zero",
                     ctrl.pause, ctrl.exception_flush, redirect_valid, redirect_pc, stall_cycles);
        end
        model_reset();
        mem_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_pause();
        test_flush();
        test_drain();
        test_idle();
        test_priority();
        test_random();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
